stage_3: RTL and testbench

STAGE_3 -- requirements
Module: stage_3

---
 rtl/stage_3.sv | 263 ++++++++++++++++++++++++++
 tb/tb_stage_3.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_3.sv
// stage_3 -- low-register update, renormalisation byte emission and
// end-of-frame termination for the range coder.
//
// Ports:
//   clk, reset                  clock; asynchronous active-low reset
//   in_valid, in_ready          stage-2 handshake (in_ready high only in RUN)
//   COMP_mux_1                  CDF: add (initial_range_1 - u) to low
//   bool_flag_1..3              bool_flag_1 selects Boolean mode; 2/3 chain further steps
//   in_symbol_1..3              Boolean symbols; 1 adds pre_low_k to low
//   u                           CDF u value (low RANGE_WIDTH bits used)
//   range_raw                   unnormalised range; its leading zeros give the shift
//   initial_range_1             normalised range before the operation
//   in_d_1..3, pre_low_1..3     Boolean shift counts and low increments
//   flush                       request termination (taken only when in_valid=0)
//   out_valid, out_count        registered result; 0..2 words this cycle
//   out_word_1, out_word_2      pre-carry words (bit 8 = carry), unused slots 0
//   out_done                    one-cycle pulse at the end of termination
module stage_3 #(
  parameter int RANGE_WIDTH = 16,
  parameter int D_SIZE      = 5,
  parameter int LOW_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   COMP_mux_1,
  input  logic                   bool_flag_1,
  input  logic                   bool_flag_2,
  input  logic                   bool_flag_3,
  input  logic                   in_symbol_1,
  input  logic                   in_symbol_2,
  input  logic                   in_symbol_3,
  input  logic [RANGE_WIDTH:0]   u,
  input  logic [RANGE_WIDTH-1:0] range_raw,
  input  logic [RANGE_WIDTH-1:0] initial_range_1,
  input  logic [D_SIZE-1:0]      in_d_1,
  input  logic [D_SIZE-1:0]      in_d_2,
  input  logic [D_SIZE-1:0]      in_d_3,
  input  logic [RANGE_WIDTH-1:0] pre_low_1,
  input  logic [RANGE_WIDTH-1:0] pre_low_2,
  input  logic [RANGE_WIDTH-1:0] pre_low_3,
  input  logic                   flush,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [1:0]             out_count,
  output logic [15:0]            out_word_1,
  output logic [15:0]            out_word_2,
  output logic                   out_done
);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  typedef struct packed {
    logic [LOW_WIDTH-1:0] low;
    logic signed [5:0]    cnt;
    logic [1:0]           n;
    logic [15:0]          w1;
    logic [15:0]          w2;
  } step_t;

  localparam logic signed [5:0]    CNT_INIT = -6'sd9;
  localparam logic [LOW_WIDTH-1:0] FL_ROUND = LOW_WIDTH'(32'h3FFF);
  localparam logic [LOW_WIDTH-1:0] FL_BIT   = LOW_WIDTH'(32'h4000);

  function automatic logic [LOW_WIDTH-1:0] low_mask(input int k);
    return (LOW_WIDTH'(1) << k) - LOW_WIDTH'(1);
  endfunction

  // Leading-zero count of the range; an all-zero range yields 0.
  function automatic logic [D_SIZE-1:0] lzc(input logic [RANGE_WIDTH-1:0] v);
    logic [D_SIZE-1:0]      n;
    logic                   seen;
    logic [RANGE_WIDTH-1:0] t;
    n    = '0;
    seen = 1'b0;
    t    = v;
    for (int unsigned i = 0; i < RANGE_WIDTH; i++) begin
      if (!seen) begin
        if (t[RANGE_WIDTH-1]) seen = 1'b1;
        else                  n = n + D_SIZE'(1);
      end
      t = t << 1;
    end
    if (!seen) n = '0;
    return n;
  endfunction

  // One renormalisation step: emit whole bytes above the counter, then shift.
  function automatic step_t renorm(input logic [LOW_WIDTH-1:0] low,
                                   input logic signed [5:0]    cnt,
                                   input logic [D_SIZE-1:0]    d);
    step_t r;
    int    s, sh_hi, sh_lo;
    r     = '0;
    r.low = low;
    r.cnt = cnt;
    s     = int'(cnt) + int'(d);
    sh_hi = int'(cnt) + 16;
    sh_lo = int'(cnt) + 8;
    if (s >= 8) begin
      r.w1  = 16'(r.low >> sh_hi);
      r.low = r.low & low_mask(sh_hi);
      r.w2  = 16'(r.low >> sh_lo);
      r.low = r.low & low_mask(sh_lo);
      r.n   = 2'd2;
      r.cnt = 6'(s - 16);
    end else if (s >= 0) begin
      r.w1  = 16'(r.low >> sh_hi);
      r.low = r.low & low_mask(sh_hi);
      r.n   = 2'd1;
      r.cnt = 6'(s - 8);
    end else begin
      r.cnt = 6'(s);
    end
    r.low = r.low << d;
    return r;
  endfunction

  // Boolean step chained onto earlier ones; earlier words keep the first slot.
  function automatic step_t bool_step(input step_t                  acc,
                                      input logic                   sym,
                                      input logic [RANGE_WIDTH-1:0] inc,
                                      input logic [D_SIZE-1:0]      d);
    step_t                r;
    logic [LOW_WIDTH-1:0] low;
    low = sym ? acc.low + LOW_WIDTH'(inc) : acc.low;
    r   = renorm(low, acc.cnt, d);
    if (acc.n != 2'd0) begin
      r.w2 = r.w1;
      r.w1 = acc.w1;
      r.n  = (r.n == 2'd0) ? 2'd1 : 2'd2;
    end
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [LOW_WIDTH-1:0] low_q, low_d;
  logic signed [5:0]    cnt_q, cnt_d;
  logic [LOW_WIDTH-1:0] e_q, e_d;
  logic signed [5:0]    ec_q, ec_d;
  logic signed [5:0]    es_q, es_d;
  logic                 valid_q, valid_d;
  logic [1:0]           count_q, count_d;
  logic [15:0]          w1_q, w1_d;
  logic [15:0]          w2_q, w2_d;
  logic                 done_q, done_d;

  step_t                seed, b1, b2, b3, step;
  logic [LOW_WIDTH-1:0] cdf_low;
  int                   fsh;
  logic                 unused_u_msb;

  assign unused_u_msb = u[RANGE_WIDTH];

  always_comb begin
    state_d = state_q;
    low_d   = low_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    ec_d    = ec_q;
    es_d    = es_q;
    valid_d = 1'b0;
    count_d = 2'd0;
    w1_d    = '0;
    w2_d    = '0;
    done_d  = 1'b0;
    seed    = '0;
    b1      = '0;
    b2      = '0;
    b3      = '0;
    step    = '0;
    cdf_low = '0;
    fsh     = 0;
    case (state_q)
      RUN: begin
        if (in_valid) begin
          if (!bool_flag_1) begin
            cdf_low = COMP_mux_1 ? low_q + LOW_WIDTH'(initial_range_1)
                                   - LOW_WIDTH'(u[RANGE_WIDTH-1:0])
                                 : low_q;
            step = renorm(cdf_low, cnt_q, lzc(range_raw));
          end else begin
            seed.low = low_q;
            seed.cnt = cnt_q;
            b1 = bool_step(seed, in_symbol_1, pre_low_1, in_d_1);
            b2 = bool_flag_2 ? bool_step(b1, in_symbol_2, pre_low_2, in_d_2) : b1;
            b3 = (bool_flag_2 && bool_flag_3)
                 ? bool_step(b2, in_symbol_3, pre_low_3, in_d_3) : b2;
            step = b3;
          end
          low_d   = step.low;
          cnt_d   = step.cnt;
          valid_d = 1'b1;
          count_d = step.n;
          w1_d    = step.w1;
          w2_d    = step.w2;
        end else if (flush) begin
          e_d     = ((low_q + FL_ROUND) & ~FL_ROUND) | FL_BIT;
          ec_d    = cnt_q;
          es_d    = 6'(int'(cnt_q) + 10);
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (int'(es_q) > 0) begin
          fsh     = int'(ec_q) + 16;
          valid_d = 1'b1;
          count_d = 2'd1;
          w1_d    = 16'(e_q >> fsh);
          e_d     = e_q & low_mask(fsh);
          es_d    = es_q - 6'sd8;
          ec_d    = ec_q - 6'sd8;
          if (int'(es_q) <= 8) state_d = DONE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        low_d   = '0;
        cnt_d   = CNT_INIT;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      low_q   <= '0;
      cnt_q   <= CNT_INIT;
      e_q     <= '0;
      ec_q    <= '0;
      es_q    <= '0;
      valid_q <= 1'b0;
      count_q <= 2'd0;
      w1_q    <= '0;
      w2_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      ec_q    <= ec_d;
      es_q    <= es_d;
      valid_q <= valid_d;
      count_q <= count_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      done_q  <= done_d;
    end
  end

  assign in_ready   = (state_q == RUN);
  assign out_valid  = valid_q;
  assign out_count  = count_q;
  assign out_word_1 = w1_q;
  assign out_word_2 = w2_q;
  assign out_done   = done_q;

endmodule

// File: tb/tb_stage_3.sv
// tb_stage_3 -- randomized scoreboard bench for stage_3 with a behavioural
// model of the low register, byte emission and termination.
module tb_stage_3;

  localparam longint TWO32 = 64'h1_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, COMP_mux_1, bool_flag_1, bool_flag_2, bool_flag_3;
  logic        in_symbol_1, in_symbol_2, in_symbol_3;
  logic [16:0] u;
  logic [15:0] range_raw, initial_range_1;
  logic [4:0]  in_d_1, in_d_2, in_d_3;
  logic [15:0] pre_low_1, pre_low_2, pre_low_3;
  logic        flush;
  logic        in_ready, out_valid, out_done;
  logic [1:0]  out_count;
  logic [15:0] out_word_1, out_word_2;

  stage_3 #(.RANGE_WIDTH(16), .D_SIZE(5), .LOW_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .COMP_mux_1(COMP_mux_1),
    .bool_flag_1(bool_flag_1), .bool_flag_2(bool_flag_2), .bool_flag_3(bool_flag_3),
    .in_symbol_1(in_symbol_1), .in_symbol_2(in_symbol_2), .in_symbol_3(in_symbol_3),
    .u(u), .range_raw(range_raw), .initial_range_1(initial_range_1),
    .in_d_1(in_d_1), .in_d_2(in_d_2), .in_d_3(in_d_3),
    .pre_low_1(pre_low_1), .pre_low_2(pre_low_2), .pre_low_3(pre_low_3),
    .flush(flush), .in_ready(in_ready), .out_valid(out_valid), .out_count(out_count),
    .out_word_1(out_word_1), .out_word_2(out_word_2), .out_done(out_done)
  );

  always #5 clk = ~clk;

  typedef struct { bit done; int cnt; int w1; int w2; } exp_t;
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  longint mL;
  int     mcnt;
  int     wq[$];

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint pow2(input int k);
    return longint'(1) << k;
  endfunction

  function automatic int lz(input logic [15:0] r);
    int v, d;
    v = int'(r);
    d = 0;
    if (v != 0) while (v < 32768) begin v = v * 2; d++; end
    return d;
  endfunction

  task automatic emit_top(input int k);
    wq.push_back(int'((mL / pow2(k)) % 65536));
    mL = mL % pow2(k);
  endtask

  task automatic m_step(input int d);
    int s;
    s = mcnt + d;
    if (s >= 8) begin
      emit_top(mcnt + 16);
      emit_top(mcnt + 8);
      mcnt = s - 16;
    end else if (s >= 0) begin
      emit_top(mcnt + 16);
      mcnt = s - 8;
    end else begin
      mcnt = s;
    end
    mL = (mL * pow2(d)) % TWO32;
  endtask

  task automatic model_reset();
    mL = 0;
    mcnt = -9;
    wq.delete();
    sb.delete();
  endtask

  task automatic push_item(input bit dn, input int c, input int a, input int b);
    exp_t it;
    it.done = dn; it.cnt = c; it.w1 = a; it.w2 = b;
    sb.push_back(it);
  endtask

  task automatic push_model();
    push_item(1'b0, wq.size(), (wq.size() > 0) ? wq[0] : 0, (wq.size() > 1) ? wq[1] : 0);
  endtask

  task automatic junk();
    COMP_mux_1 = 1'($urandom); bool_flag_2 = 1'($urandom); bool_flag_3 = 1'($urandom);
    in_symbol_1 = 1'($urandom); in_symbol_2 = 1'($urandom); in_symbol_3 = 1'($urandom);
    u = 17'($urandom); range_raw = 16'($urandom); initial_range_1 = 16'($urandom);
    in_d_1 = 5'($urandom); in_d_2 = 5'($urandom); in_d_3 = 5'($urandom);
    pre_low_1 = 16'($urandom); pre_low_2 = 16'($urandom); pre_low_3 = 16'($urandom);
  endtask

  task automatic drive_idle();
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic cdf(input bit comp, input logic [15:0] ir, input logic [16:0] uu,
                     input logic [15:0] rr, input bit fl, input bit dir,
                     input int ec, input int ew1, input int ew2);
    @(negedge clk);
    check("in_ready_run", in_ready, 1);
    junk();
    in_valid = 1'b1; flush = fl; bool_flag_1 = 1'b0; COMP_mux_1 = comp;
    initial_range_1 = ir; u = uu; range_raw = rr;
    wq.delete();
    if (comp) mL = (mL + TWO32 + longint'(ir) - longint'(uu[15:0])) % TWO32;
    m_step(lz(rr));
    if (dir) push_item(1'b0, ec, ew1, ew2);
    else push_model();
  endtask

  task automatic boolean(input bit f2, input bit f3, input bit s1, input bit s2, input bit s3,
                         input logic [15:0] p1, input logic [15:0] p2, input logic [15:0] p3,
                         input logic [4:0] d1, input logic [4:0] d2, input logic [4:0] d3,
                         input bit fl, input bit dir, input int ec, input int ew1, input int ew2);
    @(negedge clk);
    check("in_ready_run", in_ready, 1);
    junk();
    in_valid = 1'b1; flush = fl; bool_flag_1 = 1'b1; bool_flag_2 = f2; bool_flag_3 = f3;
    in_symbol_1 = s1; in_symbol_2 = s2; in_symbol_3 = s3;
    pre_low_1 = p1; pre_low_2 = p2; pre_low_3 = p3;
    in_d_1 = d1; in_d_2 = d2; in_d_3 = d3;
    wq.delete();
    if (s1) mL = (mL + longint'(p1)) % TWO32;
    m_step(int'(d1));
    if (f2) begin
      if (s2) mL = (mL + longint'(p2)) % TWO32;
      m_step(int'(d2));
      if (f3) begin
        if (s3) mL = (mL + longint'(p3)) % TWO32;
        m_step(int'(d3));
      end
    end
    if (dir) push_item(1'b0, ec, ew1, ew2);
    else push_model();
  endtask

  task automatic do_flush(input bit dir, input int ew1);
    longint e;
    int     c, s, nw;
    @(negedge clk);
    check("in_ready_run", in_ready, 1);
    junk();
    in_valid = 1'b0; flush = 1'b1;
    e = (((mL + 64'h3FFF) / 64'h4000) * 64'h4000) % TWO32;
    e = e | 64'h4000;
    c = mcnt;
    s = c + 10;
    wq.delete();
    while (s > 0) begin
      wq.push_back(int'((e / pow2(c + 16)) % 65536));
      e = e % pow2(c + 16);
      s -= 8;
      c -= 8;
    end
    nw = wq.size();
    if (dir) push_item(1'b0, 1, ew1, 0);
    else foreach (wq[i]) push_item(1'b0, 1, wq[i], 0);
    push_item(1'b1, 0, 0, 0);
    mL = 0;
    mcnt = -9;
    // Busy cycles: one per word plus DONE; inputs offered here must be ignored.
    for (int i = 0; i <= nw; i++) begin
      @(negedge clk);
      check("in_ready_busy", in_ready, 0);
      junk();
      in_valid = 1'($urandom);
      flush = 1'($urandom);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_word_1", out_word_1, 0);
    check("rst_out_word_2", out_word_2, 0);
    check("rst_out_done", out_done, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic flush_abort();
    @(negedge clk);
    check("in_ready_run", in_ready, 1);
    junk();
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("in_ready_flush", in_ready, 0);
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every presented output must match the head of the scoreboard.
  exp_t mexp;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      if (out_valid || out_done) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
          check("unexpected_out_done", out_done, 0);
        end else begin
          mexp = sb.pop_front();
          check("out_done", out_done, mexp.done);
          check("out_valid", out_valid, !mexp.done);
          check("out_count", out_count, mexp.cnt);
          check("out_word_1", out_word_1, mexp.w1);
          check("out_word_2", out_word_2, mexp.w2);
        end
      end else begin
        check("idle_out_count", out_count, 0);
        check("idle_out_word_1", out_word_1, 0);
        check("idle_out_word_2", out_word_2, 0);
      end
    end
  end

  initial begin
    logic [15:0] ir;
    logic [4:0]  d1, d2, d3;
    bit          f2, f3;
    int          r;
    reset = 1'b0;
    in_valid = 1'b0; flush = 1'b0; bool_flag_1 = 1'b0;
    junk();
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // CDF pair from reset
    cdf(1'b1, 16'h8000, 17'h06000, 16'h1000, 1'b0, 1'b1, 0, 0, 0);
    cdf(1'b1, 16'h8000, 17'h07000, 16'h0100, 1'b0, 1'b1, 1, 'h44, 0);
    drive_idle();

    // Boolean triple then two-word CDF
    do_reset();
    boolean(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4000, 16'($urandom), 16'h2000,
            5'd1, 5'd1, 5'd1, 1'b0, 1'b1, 0, 0, 0);
    cdf(1'b0, 16'($urandom), 17'($urandom), 16'h0001, 1'b0, 1'b1, 2, 'h90, 0);
    drive_idle();

    // Flush straight after reset
    do_reset();
    do_flush(1'b1, 'h80);
    drive_idle();

    // flush alongside in_valid is ignored; reset during FLUSH aborts
    cdf(1'b1, 16'hC000, 17'h01234, 16'h0800, 1'b1, 1'b0, 0, 0, 0);
    boolean(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h3333,
            5'd3, 5'd4, 5'd9, 1'b1, 1'b0, 0, 0, 0);
    do_flush(1'b0, 0);
    cdf(1'b1, 16'hFFFF, 17'h00001, 16'h0003, 1'b0, 1'b0, 0, 0, 0);
    flush_abort();
    cdf(1'b1, 16'h9000, 17'h00100, 16'h0001, 1'b0, 1'b0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) begin
        ir = 16'($urandom);
        cdf(1'($urandom), ir, {1'($urandom), 16'($urandom_range(0, int'(ir)))},
            ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom >> $urandom_range(0, 16)),
            ($urandom_range(0, 9) == 0), 1'b0, 0, 0, 0);
      end else if (r < 80) begin
        f2 = 1'($urandom); f3 = 1'($urandom);
        d1 = 5'($urandom_range(0, 8));
        d2 = f2 ? 5'($urandom_range(0, 8 - int'(d1))) : 5'($urandom);
        d3 = (f2 && f3) ? 5'($urandom_range(0, 8 - int'(d1) - int'(d2))) : 5'($urandom);
        boolean(f2, f3, 1'($urandom), 1'($urandom), 1'($urandom),
                16'($urandom), 16'($urandom), 16'($urandom), d1, d2, d3,
                ($urandom_range(0, 9) == 0), 1'b0, 0, 0, 0);
      end else if (r < 90) begin
        drive_idle();
      end else if (r < 98) begin
        do_flush(1'b0, 0);
      end else begin
        do_reset();
      end
    end
    do_flush(1'b0, 0);
    repeat (3) drive_idle();
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
